// File: rtl/restore_sequencer.sv
// Recovery controller behind commit: stall, flush, clear map table,
// redirect fetch with ack handshake, drain, then release commit.
module restore_sequencer #(
    parameter int PC_W         = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             restoreReq_i,
    input  logic [PC_W-1:0]  restorePoint_i,
    input  logic             fetchAck_i,
    output logic             busy_o,
    output logic             commitStall_o,
    output logic             flushAll_o,
    output logic             mapClearAll_o,
    output logic             fetchRedirect_o,
    output logic [PC_W-1:0]  fetchRedirectPC_o,
    output logic [CNT_W-1:0] restoreCount_o,
    output logic             timeoutErr_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        CLEAR,
        REDIRECT,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc_reg;
    logic [CNT_W-1:0]  count;
    logic [DW-1:0]     drain_cnt;
    logic [TW-1:0]     tmr;
    logic              timeout_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (restoreReq_i) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: state_next = CLEAR;
            CLEAR: state_next = REDIRECT;
            REDIRECT: begin
                if (fetchAck_i) begin
                    state_next = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt <= DW'(1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latched PC, saturating counters and the sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_reg      <= '0;
            count       <= '0;
            drain_cnt   <= '0;
            tmr         <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && restoreReq_i) begin
                pc_reg <= restorePoint_i;
                if (count != {CNT_W{1'b1}}) begin
                    count <= count + CNT_W'(1);
                end
            end
            if (state == CLEAR) begin
                tmr <= '0;
            end
            if (state == REDIRECT) begin
                if (fetchAck_i) begin
                    drain_cnt <= DW'(DRAIN_CYCLES);
                end else if (tmr != TW'(ACK_TIMEOUT)) begin
                    tmr <= tmr + TW'(1);
                    if (tmr + TW'(1) == TW'(ACK_TIMEOUT)) begin
                        timeout_err <= 1'b1;
                    end
                end
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
        end
    end

    always_comb begin
        busy_o          = 1'b0;
        commitStall_o   = 1'b0;
        flushAll_o      = 1'b0;
        mapClearAll_o   = 1'b0;
        fetchRedirect_o = 1'b0;
        if (state != IDLE) begin
            busy_o        = 1'b1;
            commitStall_o = 1'b1;
        end
        unique case (state)
            FLUSH:    flushAll_o      = 1'b1;
            CLEAR:    mapClearAll_o   = 1'b1;
            REDIRECT: fetchRedirect_o = 1'b1;
            default:  ;
        endcase
    end

    assign fetchRedirectPC_o = pc_reg;
    assign restoreCount_o    = count;
    assign timeoutErr_o      = timeout_err;

endmodule
